// File: rtl/vsub16_seq.sv
// vsub16_seq: lane-serial signed vector subtractor, DiffV = Inval1 - Inval2.
// One shared WIDTH-bit subtractor walks LANES lanes, one lane per clock,
// after a start/done handshake.
//
// Handshake: start is sampled on every rising edge. It is accepted in IDLE,
// and also in the single DONE cycle, which allows back-to-back runs. It is
// ignored while busy is high. done is a one-cycle pulse that follows the
// edge that writes the last lane.
//
// Optional build macro VSUB_SAT_EN: when it is defined, an overflowing lane
// writes its saturated value instead of the wrapped difference.
module vsub16_seq #(
  parameter int LANES = 16,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [LANES*WIDTH-1:0]   Inval1,
  input  logic [LANES*WIDTH-1:0]   Inval2,
  output logic [LANES*WIDTH-1:0]   DiffV,
  output logic                     Overflw,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               state_dbg
);

  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CW-1:0] LAST = CW'(LANES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state;
  logic [CW-1:0]            cnt;
  logic [LANES*WIDTH-1:0]   a_reg;
  logic [LANES*WIDTH-1:0]   b_reg;

  logic [WIDTH-1:0]         lane_a;
  logic [WIDTH-1:0]         lane_b;
  logic [WIDTH-1:0]         lane_d;
  logic [WIDTH-1:0]         lane_res;
  logic                     lane_ov;

  assign state_dbg = state;

  // Shared subtractor on the lane selected by the counter, plus its overflow flag
  always_comb begin
    lane_a   = a_reg[cnt*WIDTH +: WIDTH];
    lane_b   = b_reg[cnt*WIDTH +: WIDTH];
    lane_d   = lane_a - lane_b;
    lane_ov  = (lane_a[WIDTH-1] != lane_b[WIDTH-1]) &&
               (lane_d[WIDTH-1] != lane_a[WIDTH-1]);
    lane_res = lane_d;
`ifdef VSUB_SAT_EN
    // On overflow, clamp towards the sign of the minuend
    if (lane_ov) begin
      lane_res = lane_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // Sequencer: capture on accept, one lane per RUN cycle, then one done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      DiffV   <= '0;
      Overflw <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_reg   <= Inval1;
            b_reg   <= Inval2;
            DiffV   <= '0;
            Overflw <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          DiffV[cnt*WIDTH +: WIDTH] <= lane_res;
          Overflw <= Overflw | lane_ov;
          if (cnt == LAST) begin
            // The counter parks on the last lane; the next accept clears it
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vsub16_seq.sv
// tb_vsub16_seq: directed bench for vsub16_seq with hand-computed expected vectors.
module tb_vsub16_seq;

  localparam int LANES = 16;
  localparam int WIDTH = 16;
  localparam int VW    = LANES * WIDTH;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [VW-1:0]   Inval1;
  logic [VW-1:0]   Inval2;
  logic [VW-1:0]   DiffV;
  logic            Overflw;
  logic            busy;
  logic            done;
  logic [1:0]      state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  logic [VW-1:0] exp_q[$];

  vsub16_seq #(.LANES(LANES), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .Inval1    (Inval1),
    .Inval2    (Inval2),
    .DiffV     (DiffV),
    .Overflw   (Overflw),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    start  = 1'b0;
    Inval1 = '0;
    Inval2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive operands with start high from a negedge; returns just after the accept edge
  task automatic accept(input logic [VW-1:0] a, input logic [VW-1:0] b);
    Inval1 = a;
    Inval2 = b;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Walk the 16 RUN cycles after an accept, then check the done cycle
  task automatic finish_run(input string tag, input logic ov_exp,
                            input bit pulse5, input bit randbus);
    logic [VW-1:0] exp_v;
    for (int k = 0; k < LANES; k++) begin
      if (randbus) begin
        for (int j = 0; j < VW / 32; j++) begin
          Inval1[j*32 +: 32] = $urandom;
          Inval2[j*32 +: 32] = $urandom;
        end
      end
      @(negedge clk);
      check({tag, "_busy"}, VW'(busy), VW'(1'b1));
      check({tag, "_nodone"}, VW'(done), VW'(1'b0));
      if (k == 0) begin
        check({tag, "_clr_diff"}, DiffV, '0);
        check({tag, "_clr_ovf"}, VW'(Overflw), '0);
        check({tag, "_st_run"}, VW'(state_dbg), VW'(2'd1));
      end
      if (k == 1) check({tag, "_unwritten"}, VW'(DiffV[VW-1:WIDTH]), '0);
      if (pulse5 && k == 4) start = 1'b1;
      if (pulse5 && k == 5) start = 1'b0;
    end
    @(negedge clk);
    check({tag, "_done"}, VW'(done), VW'(1'b1));
    check({tag, "_busy_lo"}, VW'(busy), VW'(1'b0));
    check({tag, "_st_done"}, VW'(state_dbg), VW'(2'd2));
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, VW'(0), VW'(1));
    end else begin
      exp_v = exp_q.pop_front();
      check({tag, "_diff"}, DiffV, exp_v);
    end
    check({tag, "_ovf"}, VW'(Overflw), VW'(ov_exp));
  endtask

  // Cycle after DONE with start low: back to IDLE, results held
  task automatic check_after(input string tag, input logic [VW-1:0] held, input logic ov_exp);
    @(negedge clk);
    check({tag, "_done_lo"}, VW'(done), VW'(1'b0));
    check({tag, "_idle"}, VW'(state_dbg), VW'(2'd0));
    check({tag, "_held"}, DiffV, held);
    check({tag, "_ovf_held"}, VW'(Overflw), VW'(ov_exp));
  endtask

  initial begin
    logic [VW-1:0] va, vb, ve;
    int done_cnt, busy_cnt;

    do_reset();
    check("rst_diff", DiffV, '0);
    check("rst_ovf", VW'(Overflw), '0);
    check("rst_busy", VW'(busy), '0);
    check("rst_done", VW'(done), '0);
    check("rst_state", VW'(state_dbg), VW'(2'd0));

    // Idle for 40 cycles with start low
    done_cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
    check("idle_done_pulses", VW'(done_cnt), '0);
    check("idle_busy", VW'(busy_cnt), '0);
    check("idle_diff", DiffV, '0);
    check("idle_ovf", VW'(Overflw), '0);

    // Basic: lane i = (i+5) - 3 = i+2
    for (int i = 0; i < LANES; i++) begin
      va[i*WIDTH +: WIDTH] = 16'(i + 5);
      vb[i*WIDTH +: WIDTH] = 16'd3;
      ve[i*WIDTH +: WIDTH] = 16'(i + 2);
    end
    accept(va, vb);
    exp_q.push_back(ve);
    finish_run("basic", 1'b0, 1'b0, 1'b0);
    check_after("basic", ve, 1'b0);

    // Negative overflow on lane 7: 0x8000 - 0x0001
    va = '0; vb = '0; ve = '0;
    va[7*WIDTH +: WIDTH] = 16'h8000;
    vb[7*WIDTH +: WIDTH] = 16'h0001;
`ifdef VSUB_SAT_EN
    ve[7*WIDTH +: WIDTH] = 16'h8000;
`else
    ve[7*WIDTH +: WIDTH] = 16'h7FFF;
`endif
    accept(va, vb);
    exp_q.push_back(ve);
    finish_run("negov", 1'b1, 1'b0, 1'b0);
    check_after("negov", ve, 1'b1);

    // Positive overflow on lane 15: 0x7FFF - 0xFFFF
    va = '0; vb = '0; ve = '0;
    va[15*WIDTH +: WIDTH] = 16'h7FFF;
    vb[15*WIDTH +: WIDTH] = 16'hFFFF;
`ifdef VSUB_SAT_EN
    ve[15*WIDTH +: WIDTH] = 16'h7FFF;
`else
    ve[15*WIDTH +: WIDTH] = 16'h8000;
`endif
    accept(va, vb);
    exp_q.push_back(ve);
    finish_run("posov", 1'b1, 1'b0, 1'b0);
    check_after("posov", ve, 1'b1);

    // start re-pulsed at E5 during RUN: -1 - 1 = 0xFFFE, no overflow
    for (int i = 0; i < LANES; i++) begin
      va[i*WIDTH +: WIDTH] = 16'hFFFF;
      vb[i*WIDTH +: WIDTH] = 16'h0001;
      ve[i*WIDTH +: WIDTH] = 16'hFFFE;
    end
    accept(va, vb);
    exp_q.push_back(ve);
    finish_run("repulse", 1'b0, 1'b1, 1'b0);
    check_after("repulse", ve, 1'b0);

    // Buses randomized after accept: lane i = 0x0100*i - i = 0x00FF*i
    for (int i = 0; i < LANES; i++) begin
      va[i*WIDTH +: WIDTH] = 16'(16'h0100 * i);
      vb[i*WIDTH +: WIDTH] = 16'(i);
      ve[i*WIDTH +: WIDTH] = 16'(16'h00FF * i);
    end
    accept(va, vb);
    exp_q.push_back(ve);
    finish_run("randbus", 1'b0, 1'b0, 1'b1);
    check_after("randbus", ve, 1'b0);

    // Back-to-back: 0x0020 - 0x0030 = 0xFFF0, then start held in DONE
    for (int i = 0; i < LANES; i++) begin
      va[i*WIDTH +: WIDTH] = 16'h0020;
      vb[i*WIDTH +: WIDTH] = 16'h0030;
      ve[i*WIDTH +: WIDTH] = 16'hFFF0;
    end
    accept(va, vb);
    exp_q.push_back(ve);
    finish_run("chain1", 1'b0, 1'b0, 1'b0);
    // Second run: 0x7FFF - 0x8000 overflows in every lane
    for (int i = 0; i < LANES; i++) begin
      va[i*WIDTH +: WIDTH] = 16'h7FFF;
      vb[i*WIDTH +: WIDTH] = 16'h8000;
`ifdef VSUB_SAT_EN
      ve[i*WIDTH +: WIDTH] = 16'h7FFF;
`else
      ve[i*WIDTH +: WIDTH] = 16'hFFFF;
`endif
    end
    accept(va, vb);
    exp_q.push_back(ve);
    finish_run("chain2", 1'b1, 1'b0, 1'b0);
    check_after("chain2", ve, 1'b1);

    // Reset asserted just after E8 of a run
    for (int i = 0; i < LANES; i++) begin
      va[i*WIDTH +: WIDTH] = 16'h0050;
      vb[i*WIDTH +: WIDTH] = 16'h0002;
    end
    accept(va, vb);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_diff", DiffV, '0);
    check("midrst_ovf", VW'(Overflw), '0);
    check("midrst_busy", VW'(busy), '0);
    check("midrst_done", VW'(done), '0);
    check("midrst_state", VW'(state_dbg), VW'(2'd0));
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("midrst_no_done", VW'(done_cnt), '0);

    // Fresh run after reset: 0x0010 - 0x0001 = 0x000F
    for (int i = 0; i < LANES; i++) begin
      va[i*WIDTH +: WIDTH] = 16'h0010;
      vb[i*WIDTH +: WIDTH] = 16'h0001;
      ve[i*WIDTH +: WIDTH] = 16'h000F;
    end
    @(negedge clk);
    accept(va, vb);
    exp_q.push_back(ve);
    finish_run("postrst", 1'b0, 1'b0, 1'b0);
    check_after("postrst", ve, 1'b0);

    check("queue_empty", VW'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vsub16_seq.md
Name: vsub16_seq

Overview:
- Lane-serial 16-lane x 16-bit signed vector subtractor: DiffV = Inval1 - Inval2 per lane.
- Sequenced by a start/done handshake.
- Inverse-operation companion to the parallel vector adder; sits in the same vector ALU slot and shares its 256-bit operand buses.
- Uses one shared 16-bit subtractor over LANES cycles instead of 16 parallel units, trading latency for area.

Parameters:
- LANES, 16, number of vector lanes.
- WIDTH, 16, bits per lane; lane i occupies bits [i*WIDTH +: WIDTH].

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled each rising edge.
- Inval1  in  LANES*WIDTH  minuend vector; captured on accepted start.
- Inval2  in  LANES*WIDTH  subtrahend vector; captured on accepted start.
- DiffV  out  LANES*WIDTH  result vector, registered.
- Overflw  out  1  OR of per-lane signed overflow, registered.
- busy  out  1  high while lanes are being computed.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst_n low, async): state=IDLE, lane counter=0, operand regs=0, DiffV=0, Overflw=0, busy=0, done=0.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge E0:
  - Capture Inval1/Inval2 into internal regs.
  - Clear DiffV and Overflw to 0, counter=0.
  - Go to RUN; busy=1.
- RUN, edge k = 1..LANES:
  - Lane c = counter: d = A[c] - B[c], modulo 2^WIDTH; write DiffV lane c.
  - ov_c = (A_sign != B_sign) && (d_sign != A_sign); Overflw |= ov_c.
  - Counter increments.
  - After the edge that writes lane LANES-1 (edge E16 for defaults): go to DONE, busy=0, done=1.
- DONE lasts exactly one cycle (done high).
  - Next edge, start=0: go to IDLE, done=0.
  - Next edge, start=1: treated as a new IDLE accept (capture, clear, RUN); done=0.
- Latency: accepted start at E0 -> done high during the cycle after E16 (LANES+1 edges). Throughput: one vector per LANES+1 cycles.
- start while in RUN is ignored; operands are not recaptured and the counter is not restarted.
- Input buses may change freely after the accept edge; only captured values are used.
- DiffV/Overflw:
  - Hold their final values from DONE until the next accepted start.
  - During RUN, lanes not yet written read 0.
- Reset asserted mid-RUN: immediate return to reset values; no done pulse; the partial result is discarded.
- Counter width is clog2(LANES); it never wraps past LANES-1 while in RUN.

Optional Feature:
- Macro: VSUB_SAT_EN.
- Defined: a lane with ov_c=1 writes its saturated value instead of the wrapped one:
  - A_sign=0 -> 0x7FFF (max positive).
  - A_sign=1 -> 0x8000 (min negative).
  - Overflw is still set as above.
- Undefined: wrap-around (modulo 2^WIDTH) result only; no saturation logic is synthesized.

Test Plan:
- Reset then idle, start=0 for 40 cycles -> DiffV=0, Overflw=0, busy=0, done never pulses.
- Basic subtract, lane i: Inval1=i+5, Inval2=3, start pulse at E0:
  - busy high E0..E16, done high exactly one cycle after E16.
  - Lane i = i+2; Overflw=0.
- Negative-overflow lane, lane 7: A=0x8000, B=0x0001 -> Overflw=1.
  - Without VSUB_SAT_EN: lane 7 = 0x7FFF.
  - With VSUB_SAT_EN: lane 7 = 0x8000.
  - All other lanes (0-0): 0x0000.
- Positive-overflow lane, lane 15: A=0x7FFF, B=0xFFFF -> Overflw=1.
  - Without VSUB_SAT_EN: 0x8000.
  - With VSUB_SAT_EN: 0x7FFF.
- Handshake edges:
  - start re-pulsed at E5 during RUN -> ignored; done still one cycle after E16.
  - Inval buses randomized after E0 -> result matches the captured values.
  - start held high in the DONE cycle -> a new run begins; DiffV cleared to 0 at that edge; second done 17 edges later.
- rst_n pulsed low at E8 mid-RUN -> all outputs 0 immediately; no done pulse.
  - A new start after release gives the correct full result (e.g. all lanes 0x0010 - 0x0001 = 0x000F).
